sda_kernel_run_ctrl: RTL and testbench

Run controller for SDAccel kernels. It implements the standard host-visible control, interrupt and status registers, and sequences one action core through its go/done four-phase handshakes. It sits between the control register selector's simple reg_req/reg_ack port and the action core's go_0/done_0 lines. It also drives ap_interrupt, replacing the tied-off interrupt used by the minimal wrapper.

---
 rtl/sda_kernel_run_pkg.sv | 28 ++
 rtl/sda_kernel_irq_regs.sv | 57 +++++
 rtl/sda_kernel_run_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_sda_kernel_run_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sda_kernel_run_pkg.sv
// Shared register map, bit positions and run-FSM encoding for the SDAccel
// kernel run controller.
package sda_kernel_run_pkg;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_GIE    = 3'd1;
    localparam logic [2:0] ADDR_IER    = 3'd2;
    localparam logic [2:0] ADDR_ISR    = 3'd3;
    localparam logic [2:0] ADDR_CYCLES = 3'd4;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_IDLE_BIT  = 2;
    localparam int CTRL_READY_BIT = 3;
    localparam int CTRL_AUTO_BIT  = 7;

    localparam int IRQ_DONE_BIT  = 0;
    localparam int IRQ_READY_BIT = 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GO_REQ   = 3'd1,
        ST_GO_RTZ   = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE_ACK = 3'd4
    } run_state_e;

endpackage

// File: rtl/sda_kernel_irq_regs.sv
// GIE/IER/ISR interrupt registers with event-over-toggle priority and a
// registered level interrupt output.
module sda_kernel_irq_regs
    import sda_kernel_run_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       gie_we_i,
    input  logic       ier_we_i,
    input  logic       isr_we_i,
    input  logic [1:0] wdata_i,
    input  logic       done_evt_i,
    input  logic       ready_evt_i,
    output logic       gie_o,
    output logic [1:0] ier_o,
    output logic [1:0] isr_o,
    output logic       irq_o
);

    logic       gie_q, gie_d;
    logic [1:0] ier_q, ier_d;
    logic [1:0] isr_q, isr_d;
    logic       irq_q, irq_d;

    always_comb begin
        gie_d = gie_q;
        ier_d = ier_q;
        isr_d = isr_q;
        if (gie_we_i) gie_d = wdata_i[0];
        if (ier_we_i) ier_d = wdata_i;
        if (isr_we_i) isr_d = isr_q ^ wdata_i;
        // Events are applied after the toggle so a coincident set always wins.
        if (done_evt_i)  isr_d[IRQ_DONE_BIT]  = 1'b1;
        if (ready_evt_i) isr_d[IRQ_READY_BIT] = 1'b1;
        irq_d = gie_q & (|(isr_q & ier_q));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gie_q <= 1'b0;
            ier_q <= 2'b00;
            isr_q <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            gie_q <= gie_d;
            ier_q <= ier_d;
            isr_q <= isr_d;
            irq_q <= irq_d;
        end
    end

    assign gie_o = gie_q;
    assign ier_o = ier_q;
    assign isr_o = isr_q;
    assign irq_o = irq_q;

endmodule

// File: rtl/sda_kernel_run_ctrl.sv
// Host-visible run controller: CTRL/CYCLES registers, run-cycle counter and
// the go/done four-phase sequencing of one action core.
module sda_kernel_run_ctrl
    import sda_kernel_run_pkg::*;
#(
    parameter bit AUTO_RESTART_EN = 1'b1,
    parameter int CYCLE_CNT_WIDTH = 32
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        reg_req,
    output logic        reg_ack,
    input  logic        reg_write_en,
    input  logic [2:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        go_0r,
    input  logic        go_0a,
    input  logic        done_0r,
    output logic        done_0a,
    output logic        ap_interrupt
);

    run_state_e state_q, state_d;
    logic        reg_ack_q;
    logic [31:0] reg_rdata_q, reg_rdata_d;
    logic        go_q, go_d;
    logic        done_ack_q, done_ack_d;
    logic        ap_start_q, ap_start_d;
    logic        ap_done_q, ap_done_d;
    logic        ap_ready_q, ap_ready_d;
    logic        auto_q, auto_d;
    logic [CYCLE_CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CYCLE_CNT_WIDTH-1:0] cycles_q, cycles_d;

    logic        acc, wr_acc, rd_acc, wr_ctrl, ctrl_rd_clr;
    logic        ap_idle, start_clr, ready_evt, done_evt;
    logic        gie;
    logic [1:0]  ier, isr;
    logic [31:0] ctrl_word;
    logic        unused_wdata;

    // An access is taken on the single cycle where req is seen with ack still low.
    assign acc         = reg_req & ~reg_ack_q;
    assign wr_acc      = acc & reg_write_en;
    assign rd_acc      = acc & ~reg_write_en;
    assign wr_ctrl     = wr_acc && (reg_addr == ADDR_CTRL);
    assign ctrl_rd_clr = rd_acc && (reg_addr == ADDR_CTRL);
    assign ap_idle     = (state_q == ST_IDLE);
    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CYCLE_CNT_WIDTH'(1);
    assign unused_wdata = ^{reg_wdata[31:8], reg_wdata[6:2]};

    always_comb begin
        state_d    = state_q;
        go_d       = go_q;
        done_ack_d = done_ack_q;
        cnt_d      = ap_idle ? cnt_q : cnt_inc;
        cycles_d   = cycles_q;
        start_clr  = 1'b0;
        ready_evt  = 1'b0;
        done_evt   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ap_start_q) begin
                    state_d = ST_GO_REQ;
                    go_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GO_REQ: begin
                if (go_0a) begin
                    state_d   = ST_GO_RTZ;
                    go_d      = 1'b0;
                    start_clr = 1'b1;
                    ready_evt = 1'b1;
                end
            end
            ST_GO_RTZ: begin
                if (!go_0a) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (done_0r) begin
                    state_d    = ST_DONE_ACK;
                    done_ack_d = 1'b1;
                end
            end
            ST_DONE_ACK: begin
                if (!done_0r) begin
                    done_ack_d = 1'b0;
                    done_evt   = 1'b1;
                    // Count includes this final cycle, so CYCLES = cycles spent out of IDLE.
                    cycles_d   = cnt_inc;
                    if (auto_q || ap_start_q) begin
                        state_d = ST_GO_REQ;
                        go_d    = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ap_start_d = ap_start_q;
        ap_done_d  = ap_done_q;
        ap_ready_d = ap_ready_q;
        auto_d     = auto_q;
        if (start_clr) ap_start_d = 1'b0;
        if (wr_ctrl && reg_wdata[CTRL_START_BIT]) ap_start_d = 1'b1;
        if (wr_ctrl) auto_d = reg_wdata[CTRL_AUTO_BIT] & AUTO_RESTART_EN;
        if (ctrl_rd_clr) begin
            ap_done_d  = 1'b0;
            ap_ready_d = 1'b0;
        end
        if (done_evt)  ap_done_d  = 1'b1;
        if (ready_evt) ap_ready_d = 1'b1;
    end

    always_comb begin
        ctrl_word                 = 32'd0;
        ctrl_word[CTRL_START_BIT] = ap_start_q;
        ctrl_word[CTRL_DONE_BIT]  = ap_done_q;
        ctrl_word[CTRL_IDLE_BIT]  = ap_idle;
        ctrl_word[CTRL_READY_BIT] = ap_ready_q;
        ctrl_word[CTRL_AUTO_BIT]  = auto_q;
        reg_rdata_d = 32'd0;
        if (rd_acc) begin
            case (reg_addr)
                ADDR_CTRL:   reg_rdata_d = ctrl_word;
                ADDR_GIE:    reg_rdata_d = {31'd0, gie};
                ADDR_IER:    reg_rdata_d = {30'd0, ier};
                ADDR_ISR:    reg_rdata_d = {30'd0, isr};
                ADDR_CYCLES: reg_rdata_d = 32'(cycles_q);
                default:     reg_rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= ST_IDLE;
            reg_ack_q   <= 1'b0;
            reg_rdata_q <= 32'd0;
            go_q        <= 1'b0;
            done_ack_q  <= 1'b0;
            ap_start_q  <= 1'b0;
            ap_done_q   <= 1'b0;
            ap_ready_q  <= 1'b0;
            auto_q      <= 1'b0;
            cnt_q       <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            reg_ack_q   <= acc;
            reg_rdata_q <= reg_rdata_d;
            go_q        <= go_d;
            done_ack_q  <= done_ack_d;
            ap_start_q  <= ap_start_d;
            ap_done_q   <= ap_done_d;
            ap_ready_q  <= ap_ready_d;
            auto_q      <= auto_d;
            cnt_q       <= cnt_d;
            cycles_q    <= cycles_d;
        end
    end

    sda_kernel_irq_regs u_irq_regs (
        .clk_i       (ap_clk),
        .rst_ni      (ap_rst_n),
        .gie_we_i    (wr_acc && (reg_addr == ADDR_GIE)),
        .ier_we_i    (wr_acc && (reg_addr == ADDR_IER)),
        .isr_we_i    (wr_acc && (reg_addr == ADDR_ISR)),
        .wdata_i     (reg_wdata[1:0]),
        .done_evt_i  (done_evt),
        .ready_evt_i (ready_evt),
        .gie_o       (gie),
        .ier_o       (ier),
        .isr_o       (isr),
        .irq_o       (ap_interrupt)
    );

    assign reg_ack   = reg_ack_q;
    assign reg_rdata = reg_rdata_q;
    assign go_0r     = go_q;
    assign done_0a   = done_ack_q;

endmodule

// File: tb/tb_sda_kernel_run_ctrl.sv
// Directed/randomized bench for sda_kernel_run_ctrl with a cycle-level
// behavioural model of the register file and run bookkeeping.
module tb_sda_kernel_run_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        reg_req = 1'b0;
    logic        reg_ack;
    logic        reg_write_en = 1'b0;
    logic [2:0]  reg_addr = 3'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic [31:0] reg_rdata;
    logic        go_0r;
    logic        go_0a = 1'b0;
    logic        done_0r = 1'b0;
    logic        done_0a;
    logic        ap_interrupt;

    sda_kernel_run_ctrl dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .reg_req      (reg_req),
        .reg_ack      (reg_ack),
        .reg_write_en (reg_write_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .go_0r        (go_0r),
        .go_0a        (go_0a),
        .done_0r      (done_0r),
        .done_0a      (done_0a),
        .ap_interrupt (ap_interrupt)
    );

    always #5 ap_clk = ~ap_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of host-visible state.
    logic        m_start, m_done, m_ready, m_auto, m_gie, m_busy;
    logic [1:0]  m_ier, m_isr;
    logic [31:0] m_cnt, m_cycles;
    // Access being presented to the DUT on the coming edge.
    logic        p_act, p_we;
    logic [2:0]  p_addr;
    logic [31:0] p_wdata, exp_rdata;
    // Action-core model.
    int          a_ph, a_cnt, go_delay, done_delay, go_rises;
    logic        hold_done, ev_ready_pend, ev_done_pend, prev_go;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_start = 0; m_done = 0; m_ready = 0; m_auto = 0; m_gie = 0; m_busy = 0;
        m_ier = 0; m_isr = 0; m_cnt = 0; m_cycles = 0;
        p_act = 0; p_we = 0; p_addr = 0; p_wdata = 0; exp_rdata = 0;
        a_ph = 0; a_cnt = 0; hold_done = 0; ev_ready_pend = 0; ev_done_pend = 0; prev_go = 0;
        go_0a = 0; done_0r = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] addr);
        case (addr)
            3'd0:    m_read = {24'd0, m_auto, 3'd0, m_ready, ~m_busy, m_done, m_start};
            3'd1:    m_read = {31'd0, m_gie};
            3'd2:    m_read = {30'd0, m_ier};
            3'd3:    m_read = {30'd0, m_isr};
            3'd4:    m_read = m_cycles;
            default: m_read = 32'd0;
        endcase
    endfunction

    // Advance one clock: the edge just passed is modelled, then outputs are checked
    // and the action core reacts.
    task automatic step();
        logic ev_r, ev_d, start_now, restart_now, start_wr;
        @(negedge ap_clk);
        check("irq", 32'(ap_interrupt), 32'(m_gie & (|(m_isr & m_ier))));
        if (go_0r && !prev_go) go_rises++;
        prev_go = go_0r;
        ev_r = ev_ready_pend; ev_d = ev_done_pend;
        ev_ready_pend = 0; ev_done_pend = 0;
        start_wr = 0;
        if (p_act) exp_rdata = p_we ? 32'd0 : m_read(p_addr);
        start_now   = !m_busy && m_start;
        restart_now = ev_d && (m_auto || m_start);
        if (m_busy) m_cnt++;
        if (ev_d) begin m_cycles = m_cnt; m_cnt = 0; m_busy = restart_now; end
        if (start_now) begin m_busy = 1; m_cnt = 0; end
        if (p_act) begin
            if (p_we) begin
                case (p_addr)
                    3'd0: begin start_wr = p_wdata[0]; m_auto = p_wdata[7]; end
                    3'd1: m_gie = p_wdata[0];
                    3'd2: m_ier = p_wdata[1:0];
                    3'd3: m_isr = m_isr ^ p_wdata[1:0];
                    default: ;
                endcase
            end else if (p_addr == 3'd0) begin
                m_done = 0; m_ready = 0;
            end
            p_act = 0;
        end
        if (ev_r) begin m_start = 0; m_ready = 1; m_isr[1] = 1; end
        if (start_wr) m_start = 1;
        if (ev_d) begin m_done = 1; m_isr[0] = 1; end
        if (start_now) check("go_rise", 32'(go_0r), 32'd1);
        case (a_ph)
            1: begin
                check("go_fall", 32'(go_0r), 32'd0);
                go_0a = 0; a_cnt = 0; a_ph = 2;
            end
            2: begin
                a_cnt++;
                if (a_cnt >= done_delay) begin done_0r = 1; a_ph = 3; end
            end
            3: begin
                check("done_ack_rise", 32'(done_0a), 32'd1);
                if (!hold_done) begin done_0r = 0; ev_done_pend = 1; a_ph = 4; end
                else a_ph = 5;
            end
            4: begin
                check("done_ack_fall", 32'(done_0a), 32'd0);
                check("go_restart", 32'(go_0r), 32'(restart_now));
                a_cnt = 0; a_ph = 0;
            end
            default: ;
        endcase
        if (a_ph == 0 && go_0r) begin
            a_cnt++;
            if (a_cnt >= go_delay) begin go_0a = 1; ev_ready_pend = 1; a_ph = 1; end
        end
    endtask

    task automatic reg_access(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata);
        reg_req = 1; reg_write_en = we; reg_addr = addr; reg_wdata = wdata;
        p_act = 1; p_we = we; p_addr = addr; p_wdata = wdata;
        step();
        check($sformatf("ack_a%0d", addr), 32'(reg_ack), 32'd1);
        check($sformatf("rdata_a%0d", addr), reg_rdata, exp_rdata);
        rdata = reg_rdata;
        $display("acc %s addr=%0d wdata=0x%08h rdata=0x%08h", we ? "WR" : "RD", addr, wdata, rdata);
        reg_req = 0; reg_write_en = 0;
        step();
        check("ack_low", 32'(reg_ack), 32'd0);
        check("rdata_idle", reg_rdata, 32'd0);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((m_busy || a_ph != 0) && n < limit) begin step(); n++; end
        n_cmp++;
        assert (!m_busy && a_ph == 0) else begin
            n_bad++;
            $error("FAIL wait_idle: still busy after %0d cycles, required idle", limit);
        end
    endtask

    task automatic wait_ph(input int ph, input int limit);
        int n = 0;
        while (a_ph != ph && n < limit) begin step(); n++; end
        n_cmp++;
        assert (a_ph == ph) else begin
            n_bad++;
            $error("FAIL wait_ph: phase %0d after %0d cycles, required %0d", a_ph, limit, ph);
        end
    endtask

    task automatic do_reset();
        ap_rst_n = 0;
        #1;
        check("rst_go", 32'(go_0r), 32'd0);
        check("rst_done_a", 32'(done_0a), 32'd0);
        check("rst_irq", 32'(ap_interrupt), 32'd0);
        check("rst_ack", 32'(reg_ack), 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        model_reset();
        reg_req = 0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1;
    endtask

    initial begin
        logic [31:0] rd;
        int guard;
        int r0;
        model_reset();
        go_rises = 0;
        go_delay = 2; done_delay = 10;

        // Power-on reset.
        repeat (3) @(negedge ap_clk);
        check("por_go", 32'(go_0r), 32'd0);
        check("por_done_a", 32'(done_0a), 32'd0);
        check("por_irq", 32'(ap_interrupt), 32'd0);
        ap_rst_n = 1;
        step();
        reg_access(0, 3'd0, 32'd0, rd);
        check("ctrl_reset", rd, 32'h4);

        // Single run with fixed action timing.
        reg_access(1, 3'd0, 32'h1, rd);
        wait_idle(200);
        reg_access(0, 3'd0, 32'd0, rd);
        check("ctrl_after_run", rd, 32'hE);
        reg_access(0, 3'd0, 32'd0, rd);
        check("ctrl_cleared", rd, 32'h4);
        reg_access(0, 3'd4, 32'd0, rd);
        check("cycles_run1", rd, 32'd14);

        // Done interrupt, randomized action timing.
        reg_access(1, 3'd1, 32'h1, rd);
        reg_access(1, 3'd2, 32'h1, rd);
        go_delay = $urandom_range(1, 4); done_delay = $urandom_range(1, 12);
        reg_access(1, 3'd0, ($urandom & 32'hFFFF_FF00) | 32'h1, rd);
        wait_idle(200);
        step();
        check("irq_raised", 32'(ap_interrupt), 32'd1);
        reg_access(0, 3'd3, 32'd0, rd);
        reg_access(1, 3'd3, 32'h1, rd);
        check("irq_dropped", 32'(ap_interrupt), 32'd0);

        // Random register traffic (no CTRL writes).
        for (int i = 0; i < 8; i++) begin
            reg_access(1'($urandom_range(0, 1)), 3'($urandom_range(1, 7)), $urandom, rd);
        end
        reg_access(1, 3'd1, 32'h1, rd);
        reg_access(1, 3'd2, 32'h3, rd);

        // Auto-restart: three back-to-back runs.
        go_delay = $urandom_range(1, 4); done_delay = $urandom_range(5, 12);
        r0 = go_rises;
        reg_access(1, 3'd0, 32'h81, rd);
        guard = 0;
        while (go_rises - r0 < 3 && guard < 100) begin
            reg_access(0, 3'd0, 32'd0, rd);
            check("idle_in_auto", 32'(rd[2]), 32'd0);
            guard++;
        end
        reg_access(1, 3'd0, 32'h0, rd);
        wait_idle(300);
        check("auto_run_count", 32'(go_rises - r0), 32'd3);
        reg_access(0, 3'd0, 32'd0, rd);

        // CTRL read landing on the same edge as run completion.
        hold_done = 1;
        reg_access(1, 3'd0, 32'h1, rd);
        wait_ph(5, 200);
        hold_done = 0; done_0r = 0; ev_done_pend = 1; a_ph = 4;
        reg_access(0, 3'd0, 32'd0, rd);
        check("done_same_edge", 32'(rd[1]), 32'd0);
        reg_access(0, 3'd0, 32'd0, rd);
        check("done_next_read", 32'(rd[1]), 32'd1);
        wait_idle(50);

        // Reset while RUN.
        done_delay = 20;
        reg_access(1, 3'd0, 32'h1, rd);
        wait_ph(2, 50);
        repeat (3) step();
        check("run_done_a_low", 32'(done_0a), 32'd0);
        do_reset();
        reg_access(0, 3'd0, 32'd0, rd);
        check("ctrl_after_rst_run", rd, 32'h4);
        reg_access(0, 3'd4, 32'd0, rd);
        check("cycles_after_rst_run", rd, 32'd0);

        // Reset while DONE_ACK; run once first so CYCLES is non-zero.
        go_delay = 2; done_delay = 3;
        reg_access(1, 3'd0, 32'h1, rd);
        wait_idle(100);
        hold_done = 1;
        reg_access(1, 3'd0, 32'h1, rd);
        wait_ph(5, 200);
        check("held_done_a_high", 32'(done_0a), 32'd1);
        do_reset();
        reg_access(0, 3'd0, 32'd0, rd);
        check("ctrl_after_rst_dack", rd, 32'h4);
        reg_access(0, 3'd4, 32'd0, rd);
        check("cycles_after_rst_dack", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
